// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3 codes,
// timeout default and the access legality rule used at issue time.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 255;

  // Unsigned loads have no store counterpart, so BU/HU with a write are illegal.
  function automatic logic access_ok(input logic we, input logic [2:0] mode,
                                     input logic [1:0] off);
    logic ok;
    case (mode)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !we;
      F3_H:    ok = !off[0];
      F3_HU:   ok = !we && !off[0];
      F3_W:    ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory-side request/response bus of the load/store unit.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and store replication from the issuing
// access, load lane select and extension from the latched access.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_mode,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_ld_mode,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_ld_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_st_lane,
  output logic [31:0] o_ld_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_ld_word[{i_ld_off, 3'b000} +: 8];
  assign w_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

  always_comb begin
    o_be      = 4'b0000;
    o_st_lane = i_st_data;
    case (i_st_mode)
      F3_B, F3_BU: begin
        o_be      = 4'b0001 << i_st_off;
        o_st_lane = {4{i_st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        o_be      = 4'b0011 << {i_st_off[1], 1'b0};
        o_st_lane = {2{i_st_data[15:0]}};
      end
      F3_W:    o_be = 4'b1111;
      default: o_be = 4'b0000;
    endcase
  end

  always_comb begin
    case (i_ld_mode)
      F3_B:    o_ld_ext = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_ext = {24'd0, w_byte};
      F3_H:    o_ld_ext = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_ext = {16'd0, w_half};
      default: o_ld_ext = i_ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one aligned memory access per start, waits for ack
// with a bounded timeout, and reports completion or fault as one-cycle pulses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        MemRw,
  input  logic [2:0]  LoadStoreMode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        fault,
  lsu_if.master       mem
);

  localparam int CW = $clog2(TIMEOUT + 1);

  lsu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic        r_we, r_req, r_mem_we, r_done, r_fault;
  logic [2:0]  r_mode;
  logic [1:0]  r_off;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic [3:0]  w_be;
  logic [31:0] w_st_lane, w_ld_ext;

  lsu_align u_align (
    .i_st_mode (LoadStoreMode),
    .i_st_off  (addr[1:0]),
    .i_st_data (wdata),
    .i_ld_mode (r_mode),
    .i_ld_off  (r_off),
    .i_ld_word (mem.mem_rdata),
    .o_be      (w_be),
    .o_st_lane (w_st_lane),
    .o_ld_ext  (w_ld_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_req    <= 1'b0;
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      r_mode   <= F3_B;
      r_off    <= 2'b00;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          if (access_ok(MemRw, LoadStoreMode, addr[1:0])) begin
            r_state  <= REQ;
            r_cnt    <= '0;
            r_req    <= 1'b1;
            r_we     <= MemRw;
            r_mem_we <= MemRw;
            r_mode   <= LoadStoreMode;
            r_off    <= addr[1:0];
            r_addr   <= {addr[31:2], 2'b00};
            r_be     <= w_be;
            r_wdata  <= w_st_lane;
          end else begin
            r_state <= ERR;
            r_fault <= 1'b1;
          end
        end
        REQ: if (mem.mem_ack) begin
          r_state  <= DONE;
          r_done   <= 1'b1;
          r_req    <= 1'b0;
          r_mem_we <= 1'b0;
          if (!r_we) r_rdata <= w_ld_ext;
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          // This cycle is the TIMEOUT-th unanswered one: give up.
          r_state  <= ERR;
          r_fault  <= 1'b1;
          r_req    <= 1'b0;
          r_mem_we <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = (r_state != IDLE) | start;
  assign done          = r_done;
  assign fault         = r_fault;
  assign rdata         = r_rdata;
  assign mem.mem_req   = r_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_be    = r_be;
  assign mem.mem_wdata = r_wdata;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports SHALL be, one per line: name, direction, width, meaning (clock and reset first).
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  decode stage flags a load/store this cycle
- MemRw  in  1  1=store, 0=load
- LoadStoreMode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2)
- busy  out  1  stall request to pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load result
- fault  out  1  one-cycle misaligned/illegal/timeout pulse
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ack  in  1  memory accepts or returns data
- mem_rdata  in  32  memory read word
REQ-002 Parameter: TIMEOUT, default 255, maximum cycles mem_req may wait for mem_ack.

Function
REQ-003 The FSM SHALL have states IDLE, REQ, DONE, ERR.
REQ-004 In IDLE, start=1 with a legal, aligned access SHALL latch MemRw, mode, addr, and wdata, then enter REQ at the next edge.
REQ-005 In IDLE, start=1 with an illegal mode (011, 110, 111; or 1xx with MemRw=1), a halfword with addr[0]=1, or a word with addr[1:0]!=00 SHALL enter ERR and SHALL NOT assert mem_req.
REQ-006 In REQ, the block SHALL hold mem_req=1, and mem_addr, mem_we, mem_be, and mem_wdata SHALL stay stable until mem_ack.
REQ-007 In REQ, mem_ack=1 SHALL capture the extended load result into rdata (loads only) and enter DONE.
REQ-008 In DONE, the block SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-009 In ERR, the block SHALL assert fault=1 for exactly one cycle, then return to IDLE, with rdata unchanged.
REQ-010 A wait counter SHALL clear on REQ entry and increment each REQ cycle without ack; on reaching TIMEOUT the block SHALL drop mem_req and enter ERR.
REQ-011 Latency: start at cycle 0 gives mem_req at cycle 1; ack at cycle k gives done and valid rdata at cycle k+1.
REQ-012 busy SHALL equal (state!=IDLE) | start (combinational) and SHALL be 0 in DONE/ERR only when those states return to IDLE in the same cycle, i.e. busy=1 through DONE/ERR.
REQ-013 start while state!=IDLE SHALL be ignored, and mem_ack outside REQ SHALL be ignored.
REQ-014 Byte enables SHALL be: B/BU 0001<<addr[1:0]; H/HU 0011<<{addr[1],1'b0}; W 1111.
REQ-015 Store data SHALL be replicated: byte to all four lanes, halfword to both halves, word passed through.
REQ-016 Load extension SHALL select the lane by addr[1:0]: B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-017 rdata SHALL hold its value until the next load completes, and stores SHALL NOT modify rdata.

Reset
REQ-018 rst=1 SHALL immediately force IDLE, counter 0, rdata 0, and all outputs 0 (mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, fault); busy SHALL follow start.
REQ-019 Reset during REQ SHALL abandon the transaction with no done or fault pulse.

Structure
REQ-020 Package lsu_pkg SHALL hold the state enum, the funct3 mode constants, and the TIMEOUT default.
REQ-021 A combinational sub-module lsu_align SHALL compute mem_be, mem_wdata, and the load extension, and the FSM and counter SHALL remain in load_store_unit.

Verification
REQ-022 SW: addr=0x104, wdata=0xDEADBEEF, ack after 2 cycles -> mem_be=1111, mem_addr=0x104, mem_wdata=0xDEADBEEF, done at cycle 4.
REQ-023 SB: addr=0x103, wdata=0x000000A5 -> mem_be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
REQ-024 LB: addr=0x102, mem_rdata=0x12F03456 -> rdata=0xFFFFFFF0; the same access as LBU -> rdata=0x000000F0.
REQ-025 LH: addr=0x101 -> fault pulse one cycle after start, mem_req never asserted.
REQ-026 Timeout: load with ack never asserted -> mem_req low after 255 wait cycles, fault pulse, then IDLE.
REQ-027 rst asserted mid-REQ -> mem_req=0 same cycle, no done; a subsequent LW to 0x0 completes normally.
